// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared processor constants for the writeback stage.
//   WB_ALU/WB_MEM/WB_PC2 : write-data select encodings (3 aliases ALU)
//   NREGS                : architectural register count
//   DW                   : data width
package wb_regfile_pkg;
   localparam int DW    = 16;
   localparam int NREGS = 8;
   localparam int RW    = $clog2(NREGS);

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC2 = 2'd2;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback/read bundle between the pipeline and the regfile.
//   Writeback inputs : Enable, WBRegWrite, WBSrc, WBALUResult, WBMemData,
//                      WBPCP2, WBRd
//   Read ports       : RsA/RsB in, OA/OB out
//   Status outputs   : WriteCount, WBData, WBCommit
interface wb_regfile_if;
   import wb_regfile_pkg::*;

   logic            Enable;
   logic            WBRegWrite;
   logic [1:0]      WBSrc;
   logic [DW-1:0]   WBALUResult;
   logic [DW-1:0]   WBMemData;
   logic [DW-1:0]   WBPCP2;
   logic [RW-1:0]   WBRd;
   logic [RW-1:0]   RsA;
   logic [RW-1:0]   RsB;
   logic [DW-1:0]   OA;
   logic [DW-1:0]   OB;
   logic [DW-1:0]   WriteCount;
   logic [DW-1:0]   WBData;
   logic            WBCommit;

   modport master (
      output Enable, WBRegWrite, WBSrc, WBALUResult, WBMemData, WBPCP2, WBRd,
             RsA, RsB,
      input  OA, OB, WriteCount, WBData, WBCommit
   );

   modport slave (
      input  Enable, WBRegWrite, WBSrc, WBALUResult, WBMemData, WBPCP2, WBRd,
             RsA, RsB,
      output OA, OB, WriteCount, WBData, WBCommit
   );
endinterface

// File: rtl/wb_regfile_mux.sv
// wb_mux: combinational writeback data select.
//   src  : select (WB_ALU, WB_MEM, WB_PC2; code 3 falls back to ALU)
//   alu  : ALU result
//   mem  : load data
//   pc2  : link value
//   data : selected write data
module wb_mux
   import wb_regfile_pkg::*;
(
   input  logic [1:0]    src,
   input  logic [DW-1:0] alu,
   input  logic [DW-1:0] mem,
   input  logic [DW-1:0] pc2,
   output logic [DW-1:0] data
);
   always_comb begin
      data = alu;
      case (src)
         WB_MEM:  data = mem;
         WB_PC2:  data = pc2;
         default: data = alu;
      endcase
   end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 8 x 16-bit register file with writeback-stage write port,
// two write-through read ports and a committed-write counter.
//   CLK   : clock, rising edge
//   Reset : asynchronous active-high clear of registers and counter
//   wb    : slave side of wb_regfile_if (writeback inputs, read ports,
//           WriteCount, WBData/WBCommit for forwarding)
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic         CLK,
   input  logic         Reset,
   wb_regfile_if.slave  wb
);
   logic [DW-1:0]            data;
   logic                     commit;
   logic [NREGS-1:0][DW-1:0] regs;
   logic [DW-1:0]            count;

   wb_mux u_mux (
      .src  (wb.WBSrc),
      .alu  (wb.WBALUResult),
      .mem  (wb.WBMemData),
      .pc2  (wb.WBPCP2),
      .data (data)
   );

   assign commit = wb.Enable & wb.WBRegWrite;

   // Reset has priority over a pending commit, so nothing is written or
   // counted while it is held.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         regs  <= '0;
         count <= '0;
      end else if (commit) begin
         regs[wb.WBRd] <= data;
         count         <= count + DW'(1);
      end
   end

   // Write-through: a same-cycle commit to the read index is returned
   // directly so decode sees it without waiting for the edge.
   assign wb.OA = (commit && (wb.RsA == wb.WBRd)) ? data : regs[wb.RsA];
   assign wb.OB = (commit && (wb.RsB == wb.WBRd)) ? data : regs[wb.RsB];

   assign wb.WriteCount = count;
   assign wb.WBData     = data;
   assign wb.WBCommit   = commit;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
   logic CLK;
   logic Reset;

   wb_regfile_if bus ();

   wb_regfile dut (
      .CLK   (CLK),
      .Reset (Reset),
      .wb    (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [15:0] oa;
      logic [15:0] ob;
      logic [15:0] cnt;
      logic [15:0] data;
      logic        commit;
   } exp_t;

   exp_t  exq[$];
   string nameq[$];

   int checks   = 0;
   int failures = 0;

   // reference state: architectural registers and write count
   logic [15:0] m_r [8];
   logic [15:0] m_cnt;

   function automatic logic [15:0] sel_data(input logic [1:0] src,
      input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc2);
      if (src == 2'd1)      return mem;
      else if (src == 2'd2) return pc2;
      else                  return alu;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_cnt = 16'h0;
   endtask

   // expectation for the inputs currently on the bus
   task automatic push_exp(input string nm);
      exp_t        e;
      logic        c;
      logic [15:0] d;
      d = sel_data(bus.WBSrc, bus.WBALUResult, bus.WBMemData, bus.WBPCP2);
      c = bus.Enable & bus.WBRegWrite;
      e.data   = d;
      e.commit = c;
      e.oa     = (c && bus.RsA == bus.WBRd) ? d : m_r[bus.RsA];
      e.ob     = (c && bus.RsB == bus.WBRd) ? d : m_r[bus.RsB];
      e.cnt    = m_cnt;
      exq.push_back(e);
      nameq.push_back(nm);
   endtask

   // one writeback cycle: called at posedge+1, returns at next posedge+1
   task automatic cycle(input string nm, input logic en, input logic we,
      input logic [1:0] src, input logic [15:0] alu, input logic [15:0] mem,
      input logic [15:0] pc2, input logic [2:0] rd, input logic [2:0] rsa,
      input logic [2:0] rsb);
      bus.Enable = en;  bus.WBRegWrite = we; bus.WBSrc = src;
      bus.WBALUResult = alu; bus.WBMemData = mem; bus.WBPCP2 = pc2;
      bus.WBRd = rd; bus.RsA = rsa; bus.RsB = rsb;
      push_exp(nm);
      @(posedge CLK);
      if (!Reset && en && we) begin
         m_r[rd] = sel_data(src, alu, mem, pc2);
         m_cnt   = m_cnt + 16'd1;
      end
      #1;
   endtask

   // reset asserted between edges; outputs must clear before any edge
   task automatic reset_mid(input string nm);
      bus.Enable = 1'b0; bus.WBRegWrite = 1'b1;
      bus.RsA = 3'd3; bus.RsB = 3'd5;
      #2;
      Reset = 1'b1;
      model_clear();
      push_exp(nm);
      @(posedge CLK);
      #1;
      Reset = 1'b0;
   endtask

   task automatic chk(input string nm, input string fld,
      input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   // monitor: combinational outputs settle well before the falling edge
   always @(negedge CLK) begin
      if (exq.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exq.pop_front();
         nm = nameq.pop_front();
         chk(nm, "OA",   bus.OA,         e.oa);
         chk(nm, "OB",   bus.OB,         e.ob);
         chk(nm, "CNT",  bus.WriteCount, e.cnt);
         chk(nm, "DATA", bus.WBData,     e.data);
         chk(nm, "CMT",  {15'h0, bus.WBCommit}, {15'h0, e.commit});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      model_clear();
      bus.Enable = 1'b0; bus.WBRegWrite = 1'b0; bus.WBSrc = 2'd0;
      bus.WBALUResult = 16'h0; bus.WBMemData = 16'h0; bus.WBPCP2 = 16'h0;
      bus.WBRd = 3'd0; bus.RsA = 3'd0; bus.RsB = 3'd0;
      @(posedge CLK); #1;
      cycle("reset_state", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 2, 6);
      Reset = 1'b0;

      // write then read back
      cycle("wr_1234", 1, 1, 0, 16'h1234, 16'hAAAA, 16'h5555, 3, 0, 3);
      cycle("rd_1234", 0, 0, 0, 16'h0, 16'h0, 16'h0, 3, 3, 0);

      // same-cycle bypass on both ports
      cycle("wr_r5", 1, 1, 0, 16'h0001, 16'h0, 16'h0, 5, 0, 0);
      cycle("bypass", 1, 1, 1, 16'h1111, 16'hBEEF, 16'h2222, 5, 5, 5);
      cycle("bypass_st", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 5, 5);

      // enable gate: no write, no bypass, no count
      cycle("en_gate", 0, 1, 2, 16'h0, 16'h0, 16'h0042, 1, 1, 1);
      cycle("en_gate_after", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 3);

      // src code 3 aliases the ALU result; R0 is writable
      cycle("src3_r0", 1, 1, 3, 16'hC0DE, 16'h9999, 16'h7777, 0, 0, 4);
      cycle("src3_rd", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0);

      // reset mid-cycle clears outputs immediately
      reset_mid("reset_mid");
      cycle("post_reset", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 3, 5);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
               2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               16'($urandom), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      // counter wrap from 0xFFFF
      reset_mid("wrap_reset");
      for (int i = 0; i < 65535; i++) begin
         cycle("wrap_fill", 1, 1, 2'($urandom_range(0, 3)), 16'($urandom),
               16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      cycle("wrap_ffff", 0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 0, 7);
      cycle("wrap_last", 1, 1, 0, 16'h00AB, 16'h0, 16'h0, 2, 2, 1);
      cycle("wrap_zero", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 2, 6);

      // reset held across an edge with a commit pending
      reset_mid("rst_pend_pre");
      Reset = 1'b1;
      model_clear();
      cycle("rst_pend", 1, 1, 0, 16'h7777, 16'h0, 16'h0, 7, 0, 7);
      Reset = 1'b0;
      cycle("rst_pend_r7", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 7, 7);
      cycle("resume_wr", 1, 1, 1, 16'h0, 16'h5A5A, 16'h0, 7, 0, 0);
      cycle("resume_rd", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 7, 0);

      @(negedge CLK); #1;
      checks++;
      if (exq.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
